// File: rtl/cdc_level_sync.sv
// Receiver for signals arriving from a foreign clock domain: per-bit level synchronizer
// plus a coherent data bus that only commits after the synchronized word is stable.
module cdc_level_sync #(
    parameter int NUM_OF_BITS   = 1,
    parameter int DATA_BITS     = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int ASYNC_CLK     = 1
) (
    input  logic                   out_clk,
    input  logic                   out_resetn,
    input  logic [NUM_OF_BITS-1:0] in_bits,
    output logic [NUM_OF_BITS-1:0] out_bits,
    input  logic [DATA_BITS-1:0]   in_data,
    output logic [DATA_BITS-1:0]   out_data,
    output logic                   out_update
);

    localparam int CNT_W = (STABLE_CYCLES + 1 > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    generate
        if (ASYNC_CLK != 0) begin : g_async
            logic [NUM_OF_BITS-1:0] bit_sync  [SYNC_STAGES];
            logic [DATA_BITS-1:0]   data_sync [SYNC_STAGES];
            logic [DATA_BITS-1:0]   data_hist;
            logic [CNT_W-1:0]       cnt;
            logic [DATA_BITS-1:0]   data_q;
            logic                   update_q;
            logic                   commit;

            always_ff @(posedge out_clk) begin
                if (!out_resetn) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        bit_sync[i]  <= '0;
                        data_sync[i] <= '0;
                    end
                end else begin
                    bit_sync[0]  <= in_bits;
                    data_sync[0] <= in_data;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        bit_sync[i]  <= bit_sync[i-1];
                        data_sync[i] <= data_sync[i-1];
                    end
                end
            end

            // Commit only a word that has sat unchanged for the whole window and differs
            // from what is already published, so glitches that return never pulse.
            assign commit = (cnt == CNT_MAX) && (data_hist != data_q);

            always_ff @(posedge out_clk) begin
                if (!out_resetn) begin
                    data_hist <= '0;
                    cnt       <= '0;
                    data_q    <= '0;
                    update_q  <= 1'b0;
                end else begin
                    data_hist <= data_sync[SYNC_STAGES-1];
                    if (data_sync[SYNC_STAGES-1] != data_hist) begin
                        cnt <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (commit) begin
                        data_q <= data_hist;
                    end
                    update_q <= commit;
                end
            end

            assign out_bits   = bit_sync[SYNC_STAGES-1];
            assign out_data   = data_q;
            assign out_update = update_q;
        end else begin : g_bypass
            logic unused_clk_rst;

            assign unused_clk_rst = out_clk ^ out_resetn;
            assign out_bits       = in_bits;
            assign out_data       = in_data;
            assign out_update     = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cdc_level_sync.sv
// Directed self-checking bench for cdc_level_sync: a 3-bit asynchronous instance
// and a same-clock passthrough instance sharing one clock.
module tb_cdc_level_sync;

    logic        clk = 1'b0;
    logic        resetn_a;
    logic [2:0]  in_bits_a;
    logic [2:0]  out_bits_a;
    logic [15:0] in_data_a;
    logic [15:0] out_data_a;
    logic        out_update_a;

    logic        resetn_s;
    logic [0:0]  in_bits_s;
    logic [0:0]  out_bits_s;
    logic [15:0] in_data_s;
    logic [15:0] out_data_s;
    logic        out_update_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cdc_level_sync #(
        .NUM_OF_BITS(3), .DATA_BITS(16), .SYNC_STAGES(2), .STABLE_CYCLES(2), .ASYNC_CLK(1)
    ) dut_async (
        .out_clk(clk), .out_resetn(resetn_a),
        .in_bits(in_bits_a), .out_bits(out_bits_a),
        .in_data(in_data_a), .out_data(out_data_a),
        .out_update(out_update_a)
    );

    cdc_level_sync #(
        .NUM_OF_BITS(1), .DATA_BITS(16), .SYNC_STAGES(2), .STABLE_CYCLES(2), .ASYNC_CLK(0)
    ) dut_sync (
        .out_clk(clk), .out_resetn(resetn_s),
        .in_bits(in_bits_s), .out_bits(out_bits_s),
        .in_data(in_data_s), .out_data(out_data_s),
        .out_update(out_update_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value already applied before the next edge; commit lands on the 6th edge.
    task automatic expect_commit(input string tag, input logic [15:0] old_v, input logic [15:0] new_v);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) begin
                check_output({tag, "_hold_data"}, 32'(out_data_a), 32'(old_v));
                check_output({tag, "_hold_upd"}, 32'(out_update_a), 32'd0);
            end else begin
                check_output({tag, "_commit_data"}, 32'(out_data_a), 32'(new_v));
                check_output({tag, "_commit_upd"}, 32'(out_update_a), 32'd1);
            end
        end
        tick();
        check_output({tag, "_pulse_end"}, 32'(out_update_a), 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int n, input logic [15:0] v);
        for (int i = 0; i < n; i++) begin
            tick();
            check_output({tag, "_data"}, 32'(out_data_a), 32'(v));
            check_output({tag, "_upd"}, 32'(out_update_a), 32'd0);
        end
    endtask

    initial begin
        resetn_a  = 1'b0;
        in_bits_a = 3'b001;
        in_data_a = 16'hABCD;
        resetn_s  = 1'b1;
        in_bits_s = 1'b0;
        in_data_s = 16'h0000;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("rst_bits", 32'(out_bits_a), 32'd0);
            check_output("rst_data", 32'(out_data_a), 32'd0);
            check_output("rst_upd", 32'(out_update_a), 32'd0);
        end
        resetn_a = 1'b1;
        tick();
        check_output("rel_bits_e1", 32'(out_bits_a), 32'd0);
        tick();
        check_output("rel_bits_e2", 32'(out_bits_a), 32'd1);
        for (int i = 3; i <= 5; i++) begin
            tick();
            check_output("rel_data_wait", 32'(out_data_a), 32'd0);
            check_output("rel_upd_wait", 32'(out_update_a), 32'd0);
        end
        tick();
        check_output("rel_data_e6", 32'(out_data_a), 32'hABCD);
        check_output("rel_upd_e6", 32'(out_update_a), 32'd1);
        tick();
        check_output("rel_upd_e7", 32'(out_update_a), 32'd0);

        // Commit 0000, then a clean 0000 -> 1234 transfer with no extra pulses.
        in_data_a = 16'h0000;
        expect_commit("zero", 16'hABCD, 16'h0000);
        in_data_a = 16'h1234;
        expect_commit("c1234", 16'h0000, 16'h1234);
        expect_quiet("held1234", 10, 16'h1234);

        // Bus toggling every cycle never commits; settling on 0002 does.
        for (int i = 0; i < 20; i++) begin
            in_data_a = (i % 2 == 0) ? 16'h0002 : 16'h0001;
            tick();
            check_output("toggle_data", 32'(out_data_a), 32'h1234);
            check_output("toggle_upd", 32'(out_update_a), 32'd0);
        end
        in_data_a = 16'h0002;
        expect_commit("c0002", 16'h1234, 16'h0002);

        // One-cycle glitch away from the committed value and back.
        in_data_a = 16'h0005;
        expect_commit("c0005", 16'h0002, 16'h0005);
        expect_quiet("pre_glitch", 2, 16'h0005);
        in_data_a = 16'h0006;
        tick();
        in_data_a = 16'h0005;
        expect_quiet("glitch", 12, 16'h0005);

        // Independent bit path, two-edge latency.
        in_bits_a = 3'b000;
        tick();
        tick();
        tick();
        check_output("bits_000", 32'(out_bits_a), 32'd0);
        in_bits_a = 3'b101;
        tick();
        check_output("bits_101_e1", 32'(out_bits_a), 32'd0);
        tick();
        check_output("bits_101_e2", 32'(out_bits_a), 32'b101);

        // Mid-stream reset discards a pending commit; input reads as fresh afterwards.
        in_data_a = 16'h7777;
        tick();
        tick();
        resetn_a = 1'b0;
        tick();
        check_output("mid_rst_bits", 32'(out_bits_a), 32'd0);
        check_output("mid_rst_data", 32'(out_data_a), 32'd0);
        check_output("mid_rst_upd", 32'(out_update_a), 32'd0);
        tick();
        check_output("mid_rst_data2", 32'(out_data_a), 32'd0);
        check_output("mid_rst_upd2", 32'(out_update_a), 32'd0);
        resetn_a = 1'b1;
        expect_commit("c7777", 16'h0000, 16'h7777);
        check_output("post_rst_bits", 32'(out_bits_a), 32'b101);

        // Same-clock instance is a combinational passthrough, blind to reset.
        in_data_s = 16'h00FF;
        in_bits_s = 1'b1;
        #1;
        check_output("sync_data", 32'(out_data_s), 32'h00FF);
        check_output("sync_bits", 32'(out_bits_s), 32'd1);
        check_output("sync_upd", 32'(out_update_s), 32'd0);
        resetn_s = 1'b0;
        tick();
        check_output("sync_rst_data", 32'(out_data_s), 32'h00FF);
        check_output("sync_rst_bits", 32'(out_bits_s), 32'd1);
        check_output("sync_rst_upd", 32'(out_update_s), 32'd0);
        in_data_s = 16'h1300;
        in_bits_s = 1'b0;
        #1;
        check_output("sync_rst_data2", 32'(out_data_s), 32'h1300);
        check_output("sync_rst_bits2", 32'(out_bits_s), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
